// File: rtl/bsg_link_isdr_rx_pkg.sv
// rtl/bsg_link_isdr_rx_pkg.sv - shared types and helpers for the SDR link receiver
//
// Contents:
//   state_e     training-lock FSM state {e_train, e_locked}
//   train_word  checkerboard training pattern of a given width, MSB = 1
//               (supports link widths up to train_word_max_width_lp bits)
package bsg_link_isdr_rx_pkg;

    typedef enum logic {
        e_train  = 1'b0,
        e_locked = 1'b1
    } state_e;

    localparam int train_word_max_width_lp = 64;

    // Bit i is 1 when it sits an even distance below the MSB, giving ...1010
    // with the top bit set regardless of whether width is odd or even.
    function automatic logic [train_word_max_width_lp-1:0] train_word(input int width);
        logic [train_word_max_width_lp-1:0] w;
        w = '0;
        for (int i = 0; i < train_word_max_width_lp; i++) begin
            if (i < width) begin
                w[i] = (((width - 1 - i) % 2) == 0);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bsg_link_isdr_rx_token.sv
// rtl/bsg_link_isdr_rx_token.sv - credit counter and toggling token line
//
// Ports:
//   clk_i    in   forwarded link clock
//   reset_i  in   synchronous active-high reset
//   yumi_i   in   one legal dequeue this cycle (already qualified by the caller)
//   token_o  out  toggles once every credit_decimation_p dequeues
module bsg_link_isdr_rx_token
    import bsg_link_isdr_rx_pkg::*;
#(
    parameter int credit_decimation_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic yumi_i,
    output logic token_o
);

    localparam int cc_w_lp = (credit_decimation_p > 1) ? $clog2(credit_decimation_p) : 1;
    localparam logic [cc_w_lp-1:0] cc_last_lp = cc_w_lp'(credit_decimation_p - 1);
    localparam logic [cc_w_lp-1:0] cc_one_lp  = cc_w_lp'(1);

    logic [cc_w_lp-1:0] cc_r;
    logic               token_r;

    // The toggle happens on the same edge that wraps the counter back to 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cc_r    <= '0;
            token_r <= 1'b0;
        end else if (yumi_i) begin
            if (cc_r == cc_last_lp) begin
                cc_r    <= '0;
                token_r <= ~token_r;
            end else begin
                cc_r    <= cc_r + cc_one_lp;
            end
        end
    end

    assign token_o = token_r;

endmodule

// File: rtl/bsg_link_isdr_rx.sv
// rtl/bsg_link_isdr_rx.sv - SDR link receiver: capture, training lock, buffer, credits
//
// Ports:
//   clk_i      in   forwarded link clock (posedge only)
//   reset_i    in   synchronous active-high reset
//   io_v_i     in   link valid from the remote data flop
//   io_data_i  in   link data from the remote data flops
//   v_o        out  buffer head valid
//   data_o     out  buffer head data
//   yumi_i     in   core dequeues the head (ignored while v_o=0)
//   token_o    out  credit token, toggles every credit_decimation_p dequeues
//   locked_o   out  training complete, data is being accepted
//   error_o    out  sticky protocol error (valid word while training, or overflow)
module bsg_link_isdr_rx
    import bsg_link_isdr_rx_pkg::*;
#(
    parameter int width_p             = 8,
    parameter int els_p               = 16,
    parameter int credit_decimation_p = 4,
    parameter int lock_cycles_p       = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               io_v_i,
    input  logic [width_p-1:0] io_data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               token_o,
    output logic               locked_o,
    output logic               error_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int tc_w_lp  = (lock_cycles_p > 1) ? $clog2(lock_cycles_p) : 1;

    localparam logic [train_word_max_width_lp-1:0] train_full_lp = train_word(width_p);
    localparam logic [width_p-1:0]  train_lp   = train_full_lp[width_p-1:0];
    localparam logic [tc_w_lp-1:0]  tc_last_lp = tc_w_lp'(lock_cycles_p - 1);
    localparam logic [tc_w_lp-1:0]  tc_one_lp  = tc_w_lp'(1);
    localparam logic [ptr_w_lp:0]   ptr_one_lp = (ptr_w_lp + 1)'(1);

    // Stage C: every decision below looks only at these registered values.
    logic               c_v_r;
    logic [width_p-1:0] c_data_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            c_v_r <= 1'b0;
        end else begin
            c_v_r <= io_v_i;
        end
        c_data_r <= io_data_i;
    end

    logic c_is_train;
    assign c_is_train = !c_v_r && (c_data_r == train_lp);

    // Buffer pointers carry one extra wrap bit so full and empty differ.
    logic [width_p-1:0] mem_r [els_p];
    logic [ptr_w_lp:0]  wptr_r;
    logic [ptr_w_lp:0]  rptr_r;
    logic               empty;
    logic               full;
    logic               wr_req;
    logic               wr_en;
    logic               deq;

    state_e             state_r;
    logic [tc_w_lp-1:0] tc_r;
    logic               error_r;

    assign empty  = (wptr_r == rptr_r);
    assign full   = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp])
                 && (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]);
    assign wr_req = (state_r == e_locked) && c_v_r;
    // Full is judged on pre-dequeue occupancy, so a same-cycle yumi cannot rescue a write.
    assign wr_en  = wr_req && !full;
    assign deq    = yumi_i && !empty;

    // Training-lock FSM with its train counter and the sticky error flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_train;
            tc_r    <= '0;
            error_r <= 1'b0;
        end else begin
            case (state_r)
                e_train: begin
                    if (c_v_r) begin
                        error_r <= 1'b1;
                    end else if (c_is_train) begin
                        if (tc_r == tc_last_lp) begin
                            state_r <= e_locked;
                            tc_r    <= '0;
                        end else begin
                            tc_r    <= tc_r + tc_one_lp;
                        end
                    end else begin
                        tc_r <= '0;
                    end
                end
                e_locked: begin
                    if (wr_req && full) begin
                        error_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= e_train;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (wr_en) begin
                wptr_r <= wptr_r + ptr_one_lp;
            end
            if (deq) begin
                rptr_r <= rptr_r + ptr_one_lp;
            end
        end
    end

    // Storage needs no reset: entries are only visible once the pointers cover them.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_r[wptr_r[ptr_w_lp-1:0]] <= c_data_r;
        end
    end

    bsg_link_isdr_rx_token #(
        .credit_decimation_p(credit_decimation_p)
    ) token (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .yumi_i  (deq),
        .token_o (token_o)
    );

    assign v_o      = !empty;
    assign data_o   = mem_r[rptr_r[ptr_w_lp-1:0]];
    assign locked_o = (state_r == e_locked);
    assign error_o  = error_r;

endmodule

// File: tb/tb_bsg_link_isdr_rx.sv
// tb/tb_bsg_link_isdr_rx.sv - self-checking bench for bsg_link_isdr_rx
module tb_bsg_link_isdr_rx;

    localparam int W    = 8;
    localparam int ELS  = 16;
    localparam int DEC  = 4;
    localparam int LOCK = 8;
    localparam logic [W-1:0] TRAIN = 8'hAA;

    logic         clk;
    logic         reset;
    logic         io_v;
    logic [W-1:0] io_data;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi;
    logic         token_o;
    logic         locked_o;
    logic         error_o;

    bsg_link_isdr_rx #(
        .width_p(W), .els_p(ELS), .credit_decimation_p(DEC), .lock_cycles_p(LOCK)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .io_v_i    (io_v),
        .io_data_i (io_data),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi),
        .token_o   (token_o),
        .locked_o  (locked_o),
        .error_o   (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the link has seen, expressed as counts and a queue.
    logic [W-1:0] m_q[$];
    int           m_run;
    int           m_deqs;
    bit           m_locked;
    bit           m_err;
    bit           m_tok;
    bit           m_cv;
    logic [W-1:0] m_cd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One link edge: the word held from the previous edge is acted upon,
    // then the current pins become the held word.
    task automatic model_edge(input bit r, input bit v, input logic [W-1:0] d, input bit y);
        bit had_data;
        bit was_full;
        bit lock_now;
        if (r) begin
            m_q.delete();
            m_run = 0; m_deqs = 0;
            m_locked = 0; m_err = 0; m_tok = 0;
            m_cv = 0; m_cd = d;
            return;
        end
        had_data = (m_q.size() > 0);
        was_full = (m_q.size() == ELS);
        lock_now = 0;
        if (m_locked) begin
            if (m_cv) begin
                if (was_full) m_err = 1;
                else m_q.push_back(m_cd);
            end
        end else begin
            if (m_cv) begin
                m_err = 1;
            end else if (m_cd == TRAIN) begin
                m_run++;
                if (m_run == LOCK) lock_now = 1;
            end else begin
                m_run = 0;
            end
        end
        if (y && had_data) begin
            void'(m_q.pop_front());
            m_deqs++;
            if (m_deqs % DEC == 0) m_tok = ~m_tok;
        end
        if (lock_now) m_locked = 1;
        m_cv = v;
        m_cd = d;
    endtask

    task automatic step(input bit r, input bit v, input logic [W-1:0] d, input bit y);
        reset = r; io_v = v; io_data = d; yumi = y;
        @(posedge clk);
        model_edge(r, v, d, y);
        #1;
        check("v_o", 32'(v_o), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("data_o", 32'(data_o), 32'(m_q[0]));
        check("locked_o", 32'(locked_o), 32'(m_locked));
        check("error_o", 32'(error_o), 32'(m_err));
        check("token_o", 32'(token_o), 32'(m_tok));
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
    endtask

    task automatic train(input int n);
        for (int i = 0; i < n; i++) step(0, 0, TRAIN, 0);
    endtask

    task automatic idle(input int n, input bit y);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, y);
    endtask

    initial begin
        reset = 1; io_v = 0; io_data = '0; yumi = 0;

        // Reset state
        do_reset();
        check("rst_v_o", 32'(v_o), 32'd0);
        check("rst_locked", 32'(locked_o), 32'd0);
        check("rst_token", 32'(token_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);

        // 1: lock after 8 training words, then 0x5A with two-cycle latency
        train(LOCK);
        check("t1_not_yet_locked", 32'(locked_o), 32'd0);
        step(0, 1, 8'h5A, 0);
        check("t1_locked", 32'(locked_o), 32'd1);
        check("t1_no_bypass", 32'(v_o), 32'd0);
        step(0, 0, 8'h00, 0);
        check("t1_v_o", 32'(v_o), 32'd1);
        check("t1_data", 32'(data_o), 32'h5A);
        idle(2, 1);

        // 2: broken run does not lock
        do_reset();
        train(LOCK - 1);
        step(0, 0, 8'h00, 0);
        train(LOCK);
        check("t2_not_locked_early", 32'(locked_o), 32'd0);
        idle(2, 0);
        check("t2_locked", 32'(locked_o), 32'd1);
        check("t2_error", 32'(error_o), 32'd0);

        // 3: valid word while training is dropped and flagged
        do_reset();
        train(3);
        step(0, 1, 8'h33, 0);
        train(LOCK + 1);
        idle(4, 1);
        check("t3_error", 32'(error_o), 32'd1);
        check("t3_empty", 32'(v_o), 32'd0);

        // 4: overflow with same-cycle yumi
        do_reset();
        train(LOCK + 1);
        for (int i = 1; i <= ELS + 1; i++) step(0, 1, 8'(i), 0);
        step(0, 0, 8'h00, 1);
        check("t4_error", 32'(error_o), 32'd1);
        for (int i = 0; i < ELS + 2; i++) step(0, 0, 8'h00, m_q.size() > 0);
        check("t4_drained", 32'(v_o), 32'd0);

        // 5: continuous yumi, two toggles over eight words, none while empty
        do_reset();
        train(LOCK + 1);
        for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom), 1);
        idle(4, 1);
        check("t5_deqs", 32'(m_deqs), 32'd8);
        check("t5_token", 32'(token_o), 32'd0);
        idle(6, 1);

        // 6: reset with words buffered, then no data passes without retraining
        do_reset();
        train(LOCK + 1);
        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
        idle(1, 0);
        step(1, 0, 8'h00, 0);
        check("t6_v_o", 32'(v_o), 32'd0);
        check("t6_locked", 32'(locked_o), 32'd0);
        check("t6_token", 32'(token_o), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom), 1);
        idle(3, 1);

        // Random traffic: mostly training until locked, then mixed data and yumi
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                int sel;
                logic [W-1:0] d;
                sel = $urandom_range(0, 99);
                d = 8'($urandom);
                if (!m_locked) begin
                    if (sel < 92) step(0, 0, TRAIN, $urandom_range(0, 1) == 1);
                    else if (sel < 98 || run == 0) step(0, 0, d, 0);
                    else step(0, 1, d, 0);
                end else begin
                    step(0, sel < 55, d, $urandom_range(0, 99) < 45);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
